// File: rtl/cam_frame_writer.sv
// cam_frame_writer
//   Frame-buffer write scheduler on the fclk side of the camera stream buffer.
//   The block waits until the stream guarantees 16 back-to-back beats, issues
//   one 16-beat address/data write burst, and repeats until a frame is written.
//   Frames rotate across NBUF ring buffers. The buffer held by the downstream
//   reader is skipped, and each frame that is fully written and acknowledged is
//   reported with a one-cycle frame_done pulse.
//
// Optional feature macro: CAM_FRAME_WRITER_STATS_EN
//   When defined, the block builds burst and stall statistics counters.
//   When undefined, stat_bursts and stat_stall are tied to 0.
//
// Ports
//   fclk, rst            clock; synchronous active-high reset
//   enable               run request (level)
//   base_addr            start address of buffer 0, sampled only when idle
//   cons_hold, cons_idx  reader holds buffer cons_idx
//   sdata*               64-bit camera stream; sdata_ready is the accept strobe
//   aw_* / w_* / b_*     memory write address, data and response channels
//   frame_done/frame_idx one-cycle completion pulse and the completed buffer
//   busy                 state is not IDLE
//   stat_bursts/stall    aw handshakes / WAIT_BURST cycles with enable high
//   dbg_state            current FSM state, exposed for checkers
//
// Handshake semantics: a transfer happens on a rising fclk edge where valid
// and ready are both high. A valid that has been raised stays stable until it
// is accepted, and it never depends on ready. b_valid is a single-cycle
// response strobe, and b_ready is always 1.
module cam_frame_writer #(
  parameter int ADDR_W      = 32,
  parameter int NBUF        = 3,
  parameter int FRAME_BYTES = 614400,
  parameter int MAX_OUTST   = 4
) (
  input  logic              fclk,
  input  logic              rst,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cons_hold,
  input  logic [1:0]        cons_idx,
  input  logic [63:0]       sdata,
  input  logic              sdata_valid,
  input  logic              sdata_burst_valid,
  output logic              sdata_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic [3:0]        aw_len,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [63:0]       w_data,
  output logic              w_last,
  output logic              w_valid,
  input  logic              w_ready,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              frame_done,
  output logic [1:0]        frame_idx,
  output logic              busy,
  output logic [31:0]       stat_bursts,
  output logic [31:0]       stat_stall,
  output logic [2:0]        dbg_state
);

  localparam int BURSTS = FRAME_BYTES / 128;
  localparam int BC_W   = $clog2(BURSTS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_BURST, S_ADDR, S_DATA, S_DRAIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        cur_buf_q, cur_buf_d;
  logic [BC_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [3:0]        beat_q, beat_d;
  logic [2:0]        outst_q, outst_d;
  logic              aw_valid_q, aw_valid_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic              w_last_q, w_last_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        frame_idx_q, frame_idx_d;

  logic              aw_hs, xfer, b_take;
  logic [1:0]        nxt1, nxt_buf;
  logic [ADDR_W-1:0] addr_calc;

  function automatic logic [1:0] inc_buf(input logic [1:0] b);
    return (int'(b) == NBUF - 1) ? 2'd0 : b + 2'd1;
  endfunction

  assign aw_hs  = (state_q == S_ADDR) && aw_valid_q && aw_ready;
  assign xfer   = (state_q == S_DATA) && sdata_valid && w_ready;
  // A response with nothing outstanding is ignored so the counter cannot underflow.
  assign b_take = b_valid && (outst_q != 3'd0);

  // The next buffer skips over the one the reader is holding right now.
  assign nxt1    = inc_buf(cur_buf_q);
  assign nxt_buf = (cons_hold && (nxt1 == cons_idx)) ? inc_buf(nxt1) : nxt1;

  assign addr_calc = base_q + ADDR_W'(cur_buf_q) * ADDR_W'(FRAME_BYTES)
                   + (ADDR_W'(burst_cnt_q) << 7);

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cur_buf_d    = cur_buf_q;
    burst_cnt_d  = burst_cnt_q;
    beat_d       = beat_q;
    frame_done_d = 1'b0;
    frame_idx_d  = frame_idx_q;
    aw_addr_d    = aw_addr_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          base_d      = base_addr;
          cur_buf_d   = 2'd0;
          burst_cnt_d = '0;
          state_d     = S_WAIT_BURST;
        end
      end
      S_WAIT_BURST: begin
        if (!enable) begin
          state_d = S_DRAIN;
        end else if (sdata_burst_valid && (outst_q < 3'(MAX_OUTST))) begin
          state_d   = S_ADDR;
          aw_addr_d = addr_calc;
        end
      end
      S_ADDR: begin
        if (aw_hs) begin
          state_d = S_DATA;
          beat_d  = 4'd0;
        end
      end
      S_DATA: begin
        if (xfer) begin
          beat_d = beat_q + 4'd1;
          if (beat_q == 4'd15) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
            state_d     = (burst_cnt_q == BC_W'(BURSTS - 1)) ? S_DRAIN : S_WAIT_BURST;
          end
        end
      end
      S_DRAIN: begin
        if (outst_q == 3'd0) begin
          // An abandoned partial frame leaves the buffer pointer where it is.
          if (burst_cnt_q == BC_W'(BURSTS)) begin
            frame_done_d = 1'b1;
            frame_idx_d  = cur_buf_q;
            cur_buf_d    = nxt_buf;
            burst_cnt_d  = '0;
          end
          state_d = enable ? S_WAIT_BURST : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    aw_valid_d = (state_d == S_ADDR);
    w_last_d   = (state_d == S_DATA) && (beat_d == 4'd15);

    outst_d = outst_q;
    if (aw_hs && !b_take)      outst_d = outst_q + 3'd1;
    else if (b_take && !aw_hs) outst_d = outst_q - 3'd1;
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      base_q       <= '0;
      cur_buf_q    <= 2'd0;
      burst_cnt_q  <= '0;
      beat_q       <= 4'd0;
      outst_q      <= 3'd0;
      aw_valid_q   <= 1'b0;
      aw_addr_q    <= '0;
      w_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
      frame_idx_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      cur_buf_q    <= cur_buf_d;
      burst_cnt_q  <= burst_cnt_d;
      beat_q       <= beat_d;
      outst_q      <= outst_d;
      aw_valid_q   <= aw_valid_d;
      aw_addr_q    <= aw_addr_d;
      w_last_q     <= w_last_d;
      frame_done_q <= frame_done_d;
      frame_idx_q  <= frame_idx_d;
    end
  end

  // The data channel is a straight pass-through of the stream while in DATA.
  assign w_data      = (state_q == S_DATA) ? sdata : 64'd0;
  assign w_valid     = (state_q == S_DATA) && sdata_valid;
  assign sdata_ready = (state_q == S_DATA) && w_ready;
  assign w_last      = w_last_q;
  assign aw_valid    = aw_valid_q;
  assign aw_addr     = aw_addr_q;
  assign aw_len      = 4'd15;
  assign b_ready     = 1'b1;
  assign frame_done  = frame_done_q;
  assign frame_idx   = frame_idx_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state   = state_q;

`ifdef CAM_FRAME_WRITER_STATS_EN
  logic [31:0] stat_bursts_q, stat_stall_q;

  always_ff @(posedge fclk) begin
    if (rst) begin
      stat_bursts_q <= 32'd0;
      stat_stall_q  <= 32'd0;
    end else begin
      if (aw_hs) stat_bursts_q <= stat_bursts_q + 32'd1;
      if ((state_q == S_WAIT_BURST) && enable) stat_stall_q <= stat_stall_q + 32'd1;
    end
  end

  assign stat_bursts = stat_bursts_q;
  assign stat_stall  = stat_stall_q;
`else
  assign stat_bursts = 32'd0;
  assign stat_stall  = 32'd0;
`endif

endmodule

// File: tb/tb_cam_frame_writer.sv
// Testbench for cam_frame_writer: a randomized stream source, a memory-side
// responder, and a scoreboard. The reference model is built from buffer
// rotation arithmetic, and it queues the expected burst addresses, write data
// and frame completions. A monitor pops those queues whenever the DUT presents
// a handshake.
module tb_cam_frame_writer;
  localparam int ADDR_W      = 32;
  localparam int NBUF        = 3;
  localparam int FRAME_BYTES = 384;
  localparam int MAX_OUTST   = 2;
  localparam int BURSTS      = FRAME_BYTES / 128;

  logic              fclk = 1'b0;
  logic              rst;
  logic              enable;
  logic [ADDR_W-1:0] base_addr;
  logic              cons_hold;
  logic [1:0]        cons_idx;
  logic [63:0]       sdata;
  logic              sdata_valid, sdata_burst_valid, sdata_ready;
  logic [ADDR_W-1:0] aw_addr;
  logic [3:0]        aw_len;
  logic              aw_valid, aw_ready;
  logic [63:0]       w_data;
  logic              w_last, w_valid, w_ready;
  logic              b_valid, b_ready;
  logic              frame_done;
  logic [1:0]        frame_idx;
  logic              busy;
  logic [31:0]       stat_bursts, stat_stall;
  logic [2:0]        dbg_state;

  cam_frame_writer #(
    .ADDR_W(ADDR_W), .NBUF(NBUF), .FRAME_BYTES(FRAME_BYTES), .MAX_OUTST(MAX_OUTST)
  ) dut (
    .fclk(fclk), .rst(rst), .enable(enable), .base_addr(base_addr),
    .cons_hold(cons_hold), .cons_idx(cons_idx),
    .sdata(sdata), .sdata_valid(sdata_valid), .sdata_burst_valid(sdata_burst_valid),
    .sdata_ready(sdata_ready),
    .aw_addr(aw_addr), .aw_len(aw_len), .aw_valid(aw_valid), .aw_ready(aw_ready),
    .w_data(w_data), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
    .b_valid(b_valid), .b_ready(b_ready),
    .frame_done(frame_done), .frame_idx(frame_idx), .busy(busy),
    .stat_bursts(stat_bursts), .stat_stall(stat_stall), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 fclk = ~fclk;

  int cyc = 0;
  always @(posedge fclk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [63:0]       src_q[$];
  logic [63:0]       exp_w_q[$];
  logic [ADDR_W-1:0] exp_aw_q[$];
  logic [1:0]        exp_frame_q[$];
  int                aw_cyc_q[$];

  int checks = 0, failures = 0;
  int aw_count = 0, w_count = 0, frames_seen = 0, wl_rise = 0, last_span = 0;
  int rdy_mode = 0;
  int b_credit = 1000000;
  int b_pending = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=0x%0h required=none", name, act);
  endtask

  // ---------------- reference model ----------------
  function automatic int next_buf(input int cur, input bit hold, input int idx);
    int n;
    n = (cur + 1) % NBUF;
    if (hold && n == idx) n = (n + 1) % NBUF;
    return n;
  endfunction

  task automatic push_burst(input logic [ADDR_W-1:0] addr, input int extra_src);
    logic [63:0] w;
    exp_aw_q.push_back(addr);
    for (int i = 0; i < 16; i++) begin
      w = {$urandom, $urandom};
      src_q.push_back(w);
      exp_w_q.push_back(w);
    end
    for (int i = 0; i < extra_src; i++) src_q.push_back({$urandom, $urandom});
  endtask

  task automatic run_frames(input int n, input bit hold, input int idx);
    int b;
    b = 0;
    for (int f = 0; f < n; f++) begin
      for (int k = 0; k < BURSTS; k++)
        push_burst(base_addr + ADDR_W'(b * FRAME_BYTES) + ADDR_W'(k * 128), 0);
      exp_frame_q.push_back(2'(b));
      b = next_buf(b, hold, idx);
    end
  endtask

  // ---------------- drivers: stream source and memory responder ----------------
  initial begin
    bit take, wl;
    sdata = 64'd0; sdata_valid = 1'b0; sdata_burst_valid = 1'b0;
    aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0;
    forever begin
      @(negedge fclk);
      take = sdata_valid && sdata_ready;
      wl   = w_valid && w_ready && w_last;
      @(posedge fclk);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (wl) b_pending++;
      b_valid = 1'b0;
      if (b_pending > 0 && b_credit > 0 && (rdy_mode != 1 || $urandom_range(0, 2) == 0)) begin
        b_valid = 1'b1;
        b_pending--;
        b_credit--;
      end
      case (rdy_mode)
        1:       begin aw_ready = 1'($urandom_range(0, 1)); w_ready = 1'($urandom_range(0, 1)); end
        2:       begin aw_ready = 1'b1; w_ready = ~w_ready; end
        default: begin aw_ready = 1'b1; w_ready = 1'b1; end
      endcase
      sdata_valid       = (src_q.size() > 0);
      sdata             = (src_q.size() > 0) ? src_q[0] : 64'd0;
      sdata_burst_valid = (src_q.size() >= 16);
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int  beat_idx, w_first;
    bit  prev_fd, prev_wl;
    beat_idx = 0; w_first = 0; prev_fd = 0; prev_wl = 0;
    forever begin
      @(negedge fclk);
      if (rst) begin
        beat_idx = 0; prev_fd = 0; prev_wl = 0;
      end else begin
        if (aw_valid && aw_ready) begin
          aw_count++;
          aw_cyc_q.push_back(cyc);
          if (exp_aw_q.size() == 0) fail_now("aw_unexpected", 64'(aw_addr));
          else check("aw_addr", 64'(aw_addr), 64'(exp_aw_q.pop_front()));
        end
        if (w_valid) check("sdata_ready_mirror", 64'(sdata_ready), 64'(w_ready));
        if (w_last && !prev_wl) wl_rise++;
        prev_wl = w_last;
        if (w_valid && w_ready) begin
          w_count++;
          if (exp_w_q.size() == 0) fail_now("w_unexpected", w_data);
          else check("w_data", w_data, exp_w_q.pop_front());
          check("w_last", 64'(w_last), 64'(beat_idx == 15));
          if (beat_idx == 0) w_first = cyc;
          if (beat_idx == 15) last_span = cyc - w_first;
          beat_idx = (beat_idx + 1) % 16;
        end
        if (frame_done) begin
          frames_seen++;
          if (prev_fd) fail_now("frame_done_width", 64'(frame_idx));
          if (exp_frame_q.size() == 0) fail_now("frame_unexpected", 64'(frame_idx));
          else check("frame_idx", 64'(frame_idx), 64'(exp_frame_q.pop_front()));
        end
        prev_fd = frame_done;
      end
    end
  end

  // ---------------- phase helpers ----------------
  task automatic wait_done(input string name, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc; i++) begin
      if (exp_aw_q.size() == 0 && exp_w_q.size() == 0 && exp_frame_q.size() == 0) break;
      @(posedge fclk);
    end
    if (i == max_cyc) fail_now({name, "_timeout"}, 64'(exp_aw_q.size() + exp_w_q.size()));
  endtask

  task automatic stop_and_idle(input string name);
    @(posedge fclk);
    #2 enable = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge fclk);
      if (!busy) break;
    end
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int a0, w0, f0, r0;
    rst = 1'b1; enable = 1'b0; base_addr = 32'h1000; cons_hold = 1'b0; cons_idx = 2'd0;
    repeat (3) @(posedge fclk);
    @(negedge fclk);
    check("rst_aw_valid", 64'(aw_valid), 64'd0);
    check("rst_w_valid", 64'(w_valid), 64'd0);
    check("rst_w_last", 64'(w_last), 64'd0);
    check("rst_sdata_ready", 64'(sdata_ready), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_aw_addr", 64'(aw_addr), 64'd0);
    check("rst_frame_idx", 64'(frame_idx), 64'd0);
    check("rst_aw_len", 64'(aw_len), 64'd15);
    check("rst_b_ready", 64'(b_ready), 64'd1);
    check("rst_stat_bursts", 64'(stat_bursts), 64'd0);
    check("rst_stat_stall", 64'(stat_stall), 64'd0);
    @(posedge fclk);
    #2 rst = 1'b0;

    // Phase 1: continuous bursts, plain rotation 0,1,2, full-speed memory.
    rdy_mode = 0; base_addr = 32'h1000; cons_hold = 1'b0;
    run_frames(3, 1'b0, 0);
    aw_cyc_q.delete();
    @(posedge fclk);
    #2 enable = 1'b1;
    wait_done("p1", 2000);
    if (aw_cyc_q.size() >= 2) check("p1_burst_gap", 64'(aw_cyc_q[1] - aw_cyc_q[0]), 64'd18);
    else fail_now("p1_burst_gap", 64'(aw_cyc_q.size()));
    check("p1_burst_span", 64'(last_span), 64'd15);
    stop_and_idle("p1");
`ifdef CAM_FRAME_WRITER_STATS_EN
    check("p1_stat_bursts", 64'(stat_bursts), 64'(3 * BURSTS));
    check("p1_stat_stall_nonzero", 64'(stat_stall != 0), 64'd1);
`else
    check("p1_stat_bursts", 64'(stat_bursts), 64'd0);
    check("p1_stat_stall", 64'(stat_stall), 64'd0);
`endif

    // Phase 2: reader holds buffer 1, random readies and response delays.
    rdy_mode = 1; base_addr = 32'h0002_0000; cons_hold = 1'b1; cons_idx = 2'd1;
    run_frames(3, 1'b1, 1);
    @(posedge fclk);
    #2 enable = 1'b1;
    wait_done("p2", 6000);
    stop_and_idle("p2");

    // Phase 3: responses withheld, so at most MAX_OUTST bursts may be in flight.
    rdy_mode = 0; base_addr = 32'h3000; cons_hold = 1'b0; b_credit = 0;
    run_frames(1, 1'b0, 0);
    a0 = aw_count;
    @(posedge fclk);
    #2 enable = 1'b1;
    for (int i = 0; i < 200 && aw_count - a0 < 2; i++) @(posedge fclk);
    repeat (40) @(posedge fclk);
    check("p3_outst_limit", 64'(aw_count - a0), 64'(MAX_OUTST));
    b_credit = 1;
    for (int i = 0; i < 50 && aw_count - a0 < 3; i++) @(posedge fclk);
    check("p3_third_burst", 64'(aw_count - a0), 64'd3);
    b_credit = 1000000;
    wait_done("p3", 500);
    stop_and_idle("p3");

    // Phase 4: enable drops at beat 5, so the burst completes and the frame is abandoned.
    base_addr = 32'h4000;
    push_burst(32'h4000, 32);
    w0 = w_count; f0 = frames_seen; r0 = wl_rise;
    @(posedge fclk);
    #2 enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge fclk);
      #2;
      if (w_count - w0 >= 5) break;
    end
    enable = 1'b0;
    stop_and_idle("p4");
    check("p4_beats", 64'(w_count - w0), 64'd16);
    check("p4_no_frame_done", 64'(frames_seen - f0), 64'd0);
    check("p4_wlast_once", 64'(wl_rise - r0), 64'd1);
    check("p4_src_left", 64'(src_q.size()), 64'd32);
    src_q.delete();

    // Phase 5: w_ready toggles every cycle.
    rdy_mode = 2; base_addr = 32'h5000;
    push_burst(32'h5000, 0);
    r0 = wl_rise;
    @(posedge fclk);
    #2 enable = 1'b1;
    wait_done("p5", 300);
    check("p5_span", 64'(last_span), 64'd30);
    check("p5_wlast_once", 64'(wl_rise - r0), 64'd1);
    stop_and_idle("p5");

    // Phase 6: reset asserted in the middle of DATA.
    rdy_mode = 0; base_addr = 32'h6000;
    push_burst(32'h6000, 0);
    w0 = w_count;
    @(posedge fclk);
    #2 enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge fclk);
      #2;
      if (w_count - w0 >= 3) break;
    end
    rst = 1'b1; enable = 1'b0;
    @(posedge fclk);
    @(negedge fclk);
    check("p6_aw_valid", 64'(aw_valid), 64'd0);
    check("p6_w_valid", 64'(w_valid), 64'd0);
    check("p6_busy", 64'(busy), 64'd0);
    check("p6_stat_bursts", 64'(stat_bursts), 64'd0);
    check("p6_stat_stall", 64'(stat_stall), 64'd0);
    @(posedge fclk);
    #2 rst = 1'b0;
    src_q.delete(); exp_w_q.delete(); exp_aw_q.delete(); exp_frame_q.delete();
    b_pending = 0;

    // Phase 7: recovery after reset, one full frame with random readies.
    rdy_mode = 1; base_addr = 32'h7000;
    run_frames(1, 1'b0, 0);
    @(posedge fclk);
    #2 enable = 1'b1;
    wait_done("p7", 2000);
    stop_and_idle("p7");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cam_frame_writer.md
# cam_frame_writer

Frame-buffer write scheduler sitting on the fclk side of the camera stream buffer. It consumes the 64-bit camera stream in guaranteed 16-beat bursts and issues address/data write bursts to memory. It rotates the frames across NBUF ring buffers, skipping the buffer currently held by the downstream reader, and reports each completed frame to that reader.

## Interface
- ADDR_W, 32, memory address width
- NBUF, 3, ring buffers (>=3)
- FRAME_BYTES, 614400, bytes per frame (640x480 RGB565); must be a nonzero multiple of 128
- MAX_OUTST, 4, max write bursts awaiting response (1..7)

Ports (the clock is `fclk`; the reset is `rst`, synchronous and active-high):
- fclk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  run request, level
- base_addr  in  ADDR_W  start address of buffer 0; sampled only in IDLE
- cons_hold  in  1  reader holds buffer cons_idx
- cons_idx  in  2  buffer held by reader
- sdata  in  64  stream data
- sdata_valid  in  1  stream beat valid
- sdata_burst_valid  in  1  next 16 beats guaranteed valid
- sdata_ready  out  1  stream beat accepted
- aw_addr  out  ADDR_W  burst address
- aw_len  out  4  constant 15 (16 beats)
- aw_valid  out  1  address valid
- aw_ready  in  1  address accepted
- w_data  out  64  write data
- w_last  out  1  beat 15 of burst
- w_valid  out  1  write beat valid
- w_ready  in  1  write beat accepted
- b_valid  in  1  burst write response
- b_ready  out  1  constant 1
- frame_done  out  1  one-cycle pulse, frame fully written and acknowledged
- frame_idx  out  2  buffer of last completed frame
- busy  out  1  state != IDLE
- stat_bursts  out  32  bursts issued (see Configuration)
- stat_stall  out  32  cycles in WAIT_BURST with enable high (see Configuration)

## Operation
- States: IDLE, WAIT_BURST, ADDR, DATA, DRAIN.
- IDLE: when enable=1, latch base_addr, set cur_buf=0 and burst_cnt=0, then go to WAIT_BURST.
- WAIT_BURST:
  - If enable=0, go to DRAIN; the partial frame is abandoned and frame_done is not raised.
  - Else, if sdata_burst_valid=1 and outstanding<MAX_OUTST, go to ADDR.
- ADDR: aw_valid=1 with aw_addr = base + cur_buf*FRAME_BYTES + burst_cnt*128, computed modulo 2^ADDR_W. On aw_ready, go to DATA with beat=0.
- DATA:
  - Pass-through: w_data=sdata, w_valid=sdata_valid, sdata_ready=w_ready. Each of these is active only in DATA.
  - A beat transfers when sdata_valid&&w_ready; beat increments.
  - w_last=1 when beat==15. On the last transfer, burst_cnt increments.
  - If burst_cnt reaches FRAME_BYTES/128, go to DRAIN.
  - Otherwise go to WAIT_BURST.
- DRAIN: wait until outstanding==0.
  - If the frame is complete: pulse frame_done, set frame_idx=cur_buf, advance cur_buf, reset burst_cnt.
  - Then go to WAIT_BURST if enable=1, else IDLE.
- Buffer advance: nxt=(cur_buf+1) mod NBUF. If cons_hold and nxt==cons_idx, use (nxt+1) mod NBUF. cons_idx is sampled in the DRAIN exit cycle.
- Outstanding counter:
  - +1 on the aw handshake, −1 on b_valid.
  - When both occur in the same cycle, the counter is unchanged.
  - It never exceeds MAX_OUTST.
  - b_valid at outstanding==0 is ignored; the counter saturates at 0.
- enable falling mid-burst: ADDR and DATA always complete their burst. Bursts are never truncated.

## Timing
- Reset values:
  - State IDLE.
  - aw_valid, w_valid, w_last, sdata_ready, frame_done, busy = 0.
  - aw_addr=0, frame_idx=0.
  - All counters = 0.
  - aw_len=15 and b_ready=1, constant.
- rst is sampled at the fclk edge and overrides everything. Mid-burst reset drops the burst and all response tracking.
- aw_valid and aw_addr are registered. aw_valid rises the cycle after entering ADDR and holds stable until aw_ready.
- w_valid, w_data and sdata_ready are combinational from inputs in DATA, so there is zero added latency. w_last is registered from beat.
- Minimum burst is 1 (ADDR) + 16 (DATA) + 1 (WAIT_BURST) cycles with aw_ready and w_ready high.
- frame_done rises the cycle after the final response is counted in DRAIN.

## Configuration
- CAM_FRAME_WRITER_STATS_EN:
  - Defined: stat_bursts counts aw handshakes and stat_stall counts WAIT_BURST cycles with enable=1. Both are 32-bit, wrap at 2^32, and reset to 0.
  - Undefined: both outputs are tied to 0 and no counter logic is built.

## Test plan
- FRAME_BYTES=256, base=0x1000, enable=1, continuous bursts, aw_ready/w_ready=1, immediate b_valid:
  - aw_addr is 0x1000 then 0x1080.
  - frame_done pulses with frame_idx=0.
  - Next bursts go to 0x1100 and 0x1180.
- NBUF=3, cons_hold=1, cons_idx=1 during frame 0: the next frame writes buffer 2, with aw_addr=base+2*FRAME_BYTES.
- MAX_OUTST=2 with b_valid withheld: exactly 2 aw handshakes occur, then WAIT_BURST holds. One b_valid allows a third.
- enable dropped at beat 5 of a burst:
  - The remaining 11 beats complete with w_last on beat 15.
  - DRAIN waits for the responses, frame_done stays 0, and the block ends in IDLE.
- w_ready toggled 1/0 each cycle: sdata_ready mirrors w_ready, all 16 beats transfer in 31 cycles, and w_last asserts once.
- rst pulsed during DATA: the next cycle has aw_valid=w_valid=0, busy=0, and stat counters=0 (with CAM_FRAME_WRITER_STATS_EN).
